// File: rtl/fc_mac_unit_if.sv
// ---------------------------------------------------------------------------
// fc_mac_unit_if
// Operand and result bundle between the network read controller, the fully
// connected MAC stage and the write-back stage.
//   NrcFc_data    : batch_size*feature_size signed 32-bit elements, (b,k) at
//                   [(b*feature_size+k)*32 +: 32]
//   NrcFc_weight  : feature_size*bias_size elements, (k,j) at
//                   [(k*bias_size+j)*32 +: 32]
//   NrcFc_bias    : bias_size elements, j at [j*32 +: 32]
//   NrcFc_*_valid : operand-present levels
//   FcWb_result   : batch_size*bias_size elements, (b,j) at
//                   [(b*bias_size+j)*32 +: 32]
//   FcWb_valid / FcWb_ready : result handshake
//   Fc_busy, Fc_err         : status
// master = producer/consumer side around the unit, slave = the MAC unit.
// ---------------------------------------------------------------------------
interface fc_mac_unit_if #(
  parameter int batch_size   = 1,
  parameter int feature_size = 1,
  parameter int bias_size    = 1
);
  logic [batch_size*feature_size*32-1:0] NrcFc_data;
  logic [feature_size*bias_size*32-1:0]  NrcFc_weight;
  logic [bias_size*32-1:0]               NrcFc_bias;
  logic                                  NrcFc_data_valid;
  logic                                  NrcFc_weight_valid;
  logic                                  NrcFc_bias_valid;
  logic [batch_size*bias_size*32-1:0]    FcWb_result;
  logic                                  FcWb_valid;
  logic                                  FcWb_ready;
  logic                                  Fc_busy;
  logic                                  Fc_err;

  modport master (
    output NrcFc_data, NrcFc_weight, NrcFc_bias,
    output NrcFc_data_valid, NrcFc_weight_valid, NrcFc_bias_valid,
    output FcWb_ready,
    input  FcWb_result, FcWb_valid, Fc_busy, Fc_err
  );

  modport slave (
    input  NrcFc_data, NrcFc_weight, NrcFc_bias,
    input  NrcFc_data_valid, NrcFc_weight_valid, NrcFc_bias_valid,
    input  FcWb_ready,
    output FcWb_result, FcWb_valid, Fc_busy, Fc_err
  );
endinterface

// File: rtl/fc_mac_unit.sv
// ---------------------------------------------------------------------------
// fc_mac_unit
// Fully connected compute stage: y[b][j] = bias[j] + sum_k data[b][k]*w[k][j],
// one 32x32 multiply-accumulate per cycle, all arithmetic wrapping at 32 bits.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fc_mac_unit_if.slave (operands in, result handshake and status out)
// ---------------------------------------------------------------------------
module fc_mac_unit #(
  parameter int batch_size   = 1,
  parameter int feature_size = 1,
  parameter int bias_size    = 1
) (
  input logic          clk,
  input logic          rst_n,
  fc_mac_unit_if.slave bus
);

  localparam int BW = (batch_size   > 1) ? $clog2(batch_size)   : 1;
  localparam int JW = (bias_size    > 1) ? $clog2(bias_size)    : 1;
  localparam int KW = (feature_size > 1) ? $clog2(feature_size) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMP, S_DONE} state_t;

  state_t r_state, w_nextState;

  logic r_prevData, r_prevWeight, r_prevBias;
  logic r_haveData, r_haveWeight, r_haveBias;
  logic [batch_size*feature_size*32-1:0] r_data;
  logic [feature_size*bias_size*32-1:0]  r_weight;
  logic [bias_size*32-1:0]               r_bias;
  logic [batch_size*bias_size*32-1:0]    r_result;
  logic [BW-1:0] r_b;
  logic [JW-1:0] r_j;
  logic [KW-1:0] r_k;
  logic [31:0]   r_acc;
  logic          r_err;

  logic w_capData, w_capWeight, w_capBias, w_anyCap;
  logic w_lastK, w_lastJ, w_lastB, w_lastMac, w_handshake;
  logic [31:0] w_opA, w_opB, w_accBase, w_accNext;
  int w_dataIdx, w_weightIdx, w_biasIdx, w_resIdx;

  // An operand is captured only on a rising edge of its valid level, so a
  // valid held high after completion does not trigger another computation.
  assign w_capData   = bus.NrcFc_data_valid   & ~r_prevData;
  assign w_capWeight = bus.NrcFc_weight_valid & ~r_prevWeight;
  assign w_capBias   = bus.NrcFc_bias_valid   & ~r_prevBias;
  assign w_anyCap    = w_capData | w_capWeight | w_capBias;

  assign w_lastK     = (r_k == KW'(feature_size - 1));
  assign w_lastJ     = (r_j == JW'(bias_size - 1));
  assign w_lastB     = (r_b == BW'(batch_size - 1));
  assign w_lastMac   = w_lastK & w_lastJ & w_lastB;
  assign w_handshake = (r_state == S_DONE) & bus.FcWb_ready;

  // MAC datapath: operand selection by the loop counters. The low 32 bits of
  // the product are identical for signed and unsigned operands, so a plain
  // 32-bit multiply gives the wrapped two's-complement result.
  always_comb begin
    w_dataIdx   = (int'(r_b) * feature_size + int'(r_k)) * 32;
    w_weightIdx = (int'(r_k) * bias_size + int'(r_j)) * 32;
    w_biasIdx   = int'(r_j) * 32;
    w_resIdx    = (int'(r_b) * bias_size + int'(r_j)) * 32;
    w_opA       = r_data[w_dataIdx +: 32];
    w_opB       = r_weight[w_weightIdx +: 32];
    w_accBase   = (r_k == '0) ? r_bias[w_biasIdx +: 32] : r_acc;
    w_accNext   = w_accBase + w_opA * w_opB;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic and status outputs.
  always_comb begin
    w_nextState     = r_state;
    bus.FcWb_valid  = 1'b0;
    bus.Fc_busy     = 1'b0;
    bus.FcWb_result = r_result;
    bus.Fc_err      = r_err;
    case (r_state)
      S_IDLE: begin
        if (r_haveData && r_haveWeight && r_haveBias) w_nextState = S_COMP;
      end
      S_COMP: begin
        bus.Fc_busy = 1'b1;
        if (w_lastMac) w_nextState = S_DONE;
      end
      S_DONE: begin
        bus.Fc_busy    = 1'b1;
        bus.FcWb_valid = 1'b1;
        if (bus.FcWb_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Operand capture and have-flags. Outside COMP a capture loads the operand;
  // on the completing handshake the flags clear, but a capture in that same
  // cycle keeps its flag set. Captures during COMP only raise the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prevData   <= 1'b0;
      r_prevWeight <= 1'b0;
      r_prevBias   <= 1'b0;
      r_haveData   <= 1'b0;
      r_haveWeight <= 1'b0;
      r_haveBias   <= 1'b0;
      r_data       <= '0;
      r_weight     <= '0;
      r_bias       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_prevData   <= bus.NrcFc_data_valid;
      r_prevWeight <= bus.NrcFc_weight_valid;
      r_prevBias   <= bus.NrcFc_bias_valid;
      if (r_state == S_COMP) begin
        if (w_anyCap) r_err <= 1'b1;
      end else begin
        if (w_capData) begin
          r_data     <= bus.NrcFc_data;
          r_haveData <= 1'b1;
        end else if (w_handshake) begin
          r_haveData <= 1'b0;
        end
        if (w_capWeight) begin
          r_weight     <= bus.NrcFc_weight;
          r_haveWeight <= 1'b1;
        end else if (w_handshake) begin
          r_haveWeight <= 1'b0;
        end
        if (w_capBias) begin
          r_bias     <= bus.NrcFc_bias;
          r_haveBias <= 1'b1;
        end else if (w_handshake) begin
          r_haveBias <= 1'b0;
        end
      end
    end
  end

  // Loop counters (k innermost, then j, then b), accumulator and result
  // matrix. Counters sit at zero whenever the unit is not computing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (r_state == S_COMP) begin
      r_acc <= w_accNext;
      if (w_lastK) begin
        r_result[w_resIdx +: 32] <= w_accNext;
        r_k <= '0;
        if (w_lastJ) begin
          r_j <= '0;
          r_b <= w_lastB ? '0 : r_b + BW'(1);
        end else begin
          r_j <= r_j + JW'(1);
        end
      end else begin
        r_k <= r_k + KW'(1);
      end
    end else begin
      r_b <= '0;
      r_j <= '0;
      r_k <= '0;
    end
  end

endmodule

// File: tb/tb_fc_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_fc_mac_unit
// Drives a 1x1x1 and a 2x2x2 instance of fc_mac_unit. Expected result
// matrices are pushed to a queue when operands are driven and popped when
// the unit presents its result on the write-back handshake.
// ---------------------------------------------------------------------------
module tb_fc_mac_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fc_mac_unit_if #(.batch_size(1), .feature_size(1), .bias_size(1)) if1 ();
  fc_mac_unit_if #(.batch_size(2), .feature_size(2), .bias_size(2)) if2 ();

  fc_mac_unit #(.batch_size(1), .feature_size(1), .bias_size(1)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1)
  );

  fc_mac_unit #(.batch_size(2), .feature_size(2), .bias_size(2)) u2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if2)
  );

  int checkCount = 0;
  int passCount  = 0;
  logic [127:0] expQ[$];

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference model with 32-bit wrapping arithmetic.
  function automatic logic [127:0] model(input int nb, input int nf, input int nn,
                                         input logic [31:0] d[4], input logic [31:0] w[4],
                                         input logic [31:0] bi[2]);
    logic [127:0] r;
    logic [31:0]  acc;
    r = '0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < nn; j++) begin
        acc = bi[j];
        for (int k = 0; k < nf; k++) acc = acc + d[b*nf+k] * w[k*nn+j];
        r[(b*nn+j)*32 +: 32] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic outValid(input int inst);
    return (inst == 1) ? if1.FcWb_valid : if2.FcWb_valid;
  endfunction

  function automatic logic outBusy(input int inst);
    return (inst == 1) ? if1.Fc_busy : if2.Fc_busy;
  endfunction

  function automatic logic [127:0] outResult(input int inst);
    return (inst == 1) ? {96'd0, if1.FcWb_result} : if2.FcWb_result;
  endfunction

  task automatic setReady(input int inst, input logic v);
    if (inst == 1) if1.FcWb_ready = v;
    else           if2.FcWb_ready = v;
  endtask

  task automatic setValids(input int inst, input logic [2:0] v);
    if (inst == 1) begin
      if1.NrcFc_data_valid = v[2]; if1.NrcFc_weight_valid = v[1]; if1.NrcFc_bias_valid = v[0];
    end else begin
      if2.NrcFc_data_valid = v[2]; if2.NrcFc_weight_valid = v[1]; if2.NrcFc_bias_valid = v[0];
    end
  endtask

  // Drives operand buses; optionally pushes the model's expectation.
  task automatic applyStimulus(input int inst, input logic [31:0] d[4], input logic [31:0] w[4],
                               input logic [31:0] bi[2], input bit doPush);
    if (inst == 1) begin
      if1.NrcFc_data   = d[0];
      if1.NrcFc_weight = w[0];
      if1.NrcFc_bias   = bi[0];
      if (doPush) expQ.push_back(model(1, 1, 1, d, w, bi));
    end else begin
      if2.NrcFc_data   = {d[3], d[2], d[1], d[0]};
      if2.NrcFc_weight = {w[3], w[2], w[1], w[0]};
      if2.NrcFc_bias   = {bi[1], bi[0]};
      if (doPush) expQ.push_back(model(2, 2, 2, d, w, bi));
    end
  endtask

  // Waits (bounded) for FcWb_valid, optionally checks latency, COMP length
  // and backpressure stability, then completes the handshake and compares.
  task automatic waitAndCollect(input int inst, input string tag, input int expCycles,
                                input int expComp, input int holdCycles);
    int cnt  = 0;
    int comp = 0;
    while (!outValid(inst) && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (outBusy(inst) && !outValid(inst)) comp++;
    end
    if (!outValid(inst)) begin
      checkOutput({tag, " timeout"}, 128'd0, 128'd1);
      if (expQ.size() > 0) void'(expQ.pop_front());
      return;
    end
    if (expCycles >= 0) checkOutput({tag, " latency"}, 128'(cnt), 128'(expCycles));
    if (expComp >= 0)   checkOutput({tag, " comp cycles"}, 128'(comp), 128'(expComp));
    if (expQ.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 128'd0, 128'd1);
      return;
    end
    if (holdCycles > 0) begin
      repeat (holdCycles) @(negedge clk);
      checkOutput({tag, " valid held"}, 128'(outValid(inst)), 128'd1);
      checkOutput({tag, " result held"}, outResult(inst), expQ[0]);
    end
    setReady(inst, 1'b1);
    checkOutput({tag, " result"}, outResult(inst), expQ.pop_front());
    @(negedge clk);
    setReady(inst, 1'b0);
    checkOutput({tag, " valid after handshake"}, 128'(outValid(inst)), 128'd0);
    checkOutput({tag, " busy after handshake"}, 128'(outBusy(inst)), 128'd0);
  endtask

  logic [31:0] d[4];
  logic [31:0] w[4];
  logic [31:0] bi[2];

  initial begin
    rst_n = 1'b0;
    if1.NrcFc_data = '0; if1.NrcFc_weight = '0; if1.NrcFc_bias = '0; if1.FcWb_ready = 1'b0;
    if2.NrcFc_data = '0; if2.NrcFc_weight = '0; if2.NrcFc_bias = '0; if2.FcWb_ready = 1'b0;
    setValids(1, 3'b000);
    setValids(2, 3'b000);
    repeat (2) @(negedge clk);
    checkOutput("reset result", if2.FcWb_result, 128'd0);
    checkOutput("reset valid", 128'(if2.FcWb_valid), 128'd0);
    checkOutput("reset busy", 128'(if2.Fc_busy), 128'd0);
    checkOutput("reset err", 128'(if2.Fc_err), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1x1x1: 3*4+5, all valids together
    d = '{32'd3, 32'd0, 32'd0, 32'd0}; w = '{32'd4, 32'd0, 32'd0, 32'd0}; bi = '{32'd5, 32'd0};
    applyStimulus(1, d, w, bi, 1'b0);
    expQ.push_back(128'd17);
    setValids(1, 3'b111);
    waitAndCollect(1, "mac1", 3, 1, 0);

    // 1x1x1 wrap cases
    setValids(1, 3'b000);
    @(negedge clk);
    d = '{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0}; w = '{32'd2, 32'd0, 32'd0, 32'd0}; bi = '{32'd0, 32'd0};
    applyStimulus(1, d, w, bi, 1'b0);
    expQ.push_back(128'hFFFF_FFFE);
    setValids(1, 3'b111);
    waitAndCollect(1, "wrapPos", 3, 1, 0);
    setValids(1, 3'b000);
    @(negedge clk);
    d = '{32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0}; w = '{32'd4, 32'd0, 32'd0, 32'd0}; bi = '{32'd1, 32'd0};
    applyStimulus(1, d, w, bi, 1'b0);
    expQ.push_back(128'hFFFF_FFF5);
    setValids(1, 3'b111);
    waitAndCollect(1, "wrapNeg", 3, 1, 0);

    // 2x2x2: staggered valids, backpressure
    d = '{32'd1, 32'd2, 32'd3, 32'd4}; w = '{32'd5, 32'd6, 32'd7, 32'd8}; bi = '{32'd10, 32'd20};
    applyStimulus(2, d, w, bi, 1'b0);
    expQ.push_back({32'd70, 32'd53, 32'd42, 32'd29});
    if2.NrcFc_bias_valid = 1'b1;
    @(negedge clk);
    if2.NrcFc_weight_valid = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("A busy before data", 128'(if2.Fc_busy), 128'd0);
    if2.NrcFc_data_valid = 1'b1;
    waitAndCollect(2, "A", 10, 8, 5);

    // Valids still high: no recompute
    repeat (12) @(negedge clk);
    checkOutput("held valids busy", 128'(if2.Fc_busy), 128'd0);
    checkOutput("held valids valid", 128'(if2.FcWb_valid), 128'd0);

    // Re-capture data only: still waits for weight and bias
    if2.NrcFc_data_valid = 1'b0;
    @(negedge clk);
    d = '{32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'd7};
    applyStimulus(2, d, w, bi, 1'b0);
    if2.NrcFc_data_valid = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("data only busy", 128'(if2.Fc_busy), 128'd0);
    if2.NrcFc_weight_valid = 1'b0;
    if2.NrcFc_bias_valid   = 1'b0;
    @(negedge clk);
    applyStimulus(2, d, w, bi, 1'b1);
    if2.NrcFc_weight_valid = 1'b1;
    if2.NrcFc_bias_valid   = 1'b1;
    waitAndCollect(2, "B", 10, 8, 0);

    // Data valid toggles during COMP: sticky error, result unaffected
    checkOutput("C err before", 128'(if2.Fc_err), 128'd0);
    setValids(2, 3'b000);
    @(negedge clk);
    d = '{32'd5, 32'hFFFF_FFFA, 32'd7, 32'd8}; w = '{32'h0001_0000, 32'd3, 32'hFFFF_FFFE, 32'd9};
    bi = '{32'hFFFF_FF9C, 32'd100};
    applyStimulus(2, d, w, bi, 1'b1);
    setValids(2, 3'b111);
    repeat (3) @(negedge clk);
    checkOutput("C busy", 128'(if2.Fc_busy), 128'd1);
    if2.NrcFc_data_valid = 1'b0;
    if2.NrcFc_data = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    if2.NrcFc_data_valid = 1'b1;
    waitAndCollect(2, "C", -1, -1, 0);
    checkOutput("C err sticky", 128'(if2.Fc_err), 128'd1);

    // Reset in the middle of COMP
    setValids(2, 3'b000);
    @(negedge clk);
    d = '{32'd9, 32'd8, 32'd7, 32'd6}; w = '{32'd1, 32'd2, 32'd3, 32'd4}; bi = '{32'd1, 32'd1};
    applyStimulus(2, d, w, bi, 1'b0);
    setValids(2, 3'b111);
    repeat (4) @(negedge clk);
    checkOutput("D busy mid comp", 128'(if2.Fc_busy), 128'd1);
    setValids(2, 3'b000);
    rst_n = 1'b0;
    #1;
    checkOutput("D reset result", if2.FcWb_result, 128'd0);
    checkOutput("D reset valid", 128'(if2.FcWb_valid), 128'd0);
    checkOutput("D reset busy", 128'(if2.Fc_busy), 128'd0);
    checkOutput("D reset err", 128'(if2.Fc_err), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("D idle after reset", 128'(if2.Fc_busy), 128'd0);
    checkOutput("scoreboard drained", 128'(expQ.size()), 128'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
